// File: rtl/keypad_matrix_emulator_pkg.sv
// Shared definitions for the 4x4 keypad matrix emulator: FSM encodings,
// key-code field positions, idle row pattern and bounce LFSR taps.
package keypad_matrix_emulator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_B_IN  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_B_OUT = 3'd3,
    ST_GAP   = 3'd4
  } kp_state_t;

  // key code = {col_idx[1:0], row_idx[1:0]}
  localparam int KEY_COL_LSB = 2;
  localparam int KEY_ROW_LSB = 0;

  localparam logic [3:0]  ROW_IDLE  = 4'b1111;
  // Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [1:0] key_col(input logic [3:0] key);
    return key[KEY_COL_LSB +: 2];
  endfunction

  function automatic logic [1:0] key_row(input logic [3:0] key);
    return key[KEY_ROW_LSB +: 2];
  endfunction

endpackage

// File: rtl/keypad_matrix_emulator_if.sv
// Request/response and matrix-line bundle between a test sequencer (master)
// and the keypad emulator (slave).
interface keypad_matrix_emulator_if;
  import keypad_matrix_emulator_pkg::*;

  // Handshake: a request transfers on a clock edge where req_valid and
  // req_ready are both high; req_key is sampled only on that edge and
  // req_valid while not ready is simply ignored (no queueing).
  logic       req_valid;
  logic [3:0] req_key;
  logic       req_ready;
  logic       abort;
  logic       pressed;
  logic       busy;
  logic       done;
  logic [3:0] col;
  logic [3:0] row;
  kp_state_t  dbg_state;

  modport master (
    output req_valid, req_key, abort, col,
    input  req_ready, pressed, busy, done, row, dbg_state
  );

  modport slave (
    input  req_valid, req_key, abort, col,
    output req_ready, pressed, busy, done, row, dbg_state
  );

endinterface

// File: rtl/keypad_matrix_emulator_bounce_lfsr.sv
// 16-bit Galois LFSR used to generate contact-bounce samples; advances
// only when step is high.
module keypad_matrix_emulator_bounce_lfsr
  import keypad_matrix_emulator_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  output logic [15:0] q
);

  logic [15:0] q_next;

  always_comb begin
    q_next = {1'b0, q[15:1]};
    if (q[0]) q_next = q_next ^ LFSR_TAPS;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     q <= SEED;
    else if (step) q <= q_next;
  end

endmodule

// File: rtl/keypad_matrix_emulator.sv
// Passive 4x4 keypad model: accepts one key-press request at a time and
// answers the scanner's active-low column drive on the active-low row lines.
module keypad_matrix_emulator
  import keypad_matrix_emulator_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 10_000_000,
  parameter int unsigned BOUNCE_CYCLES = 500_000,
  parameter int unsigned BOUNCE_TICK   = 25_000,
  parameter int unsigned GAP_CYCLES    = 5_000_000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input logic                     clk,
  input logic                     reset,
  keypad_matrix_emulator_if.slave kp
);

  localparam bit          HAS_BOUNCE  = (BOUNCE_CYCLES != 0);
  localparam logic [31:0] HOLD_LOAD   = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] GAP_LOAD    = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] BOUNCE_LOAD = HAS_BOUNCE ? 32'(BOUNCE_CYCLES - 1) : 32'd0;
  localparam logic [31:0] TICK_LOAD   = 32'(BOUNCE_TICK - 1);

  kp_state_t   state, state_next;
  logic [31:0] cnt, cnt_load;
  logic [31:0] tick;
  logic        enter;
  logic        phase_end;
  logic        in_bounce;
  logic        lfsr_step;
  logic        accept;
  logic        ready_int;
  logic        pressed, pressed_next;
  logic [3:0]  key_q;
  logic [3:0]  row_q, row_next;
  logic [15:0] lfsr_q;

  assign ready_int = (state == ST_IDLE) && !reset;
  assign accept    = kp.req_valid && ready_int;
  assign phase_end = (cnt == 32'd0);
  assign in_bounce = (state == ST_B_IN) || (state == ST_B_OUT);
  // A phase exit wins over a same-cycle bounce tick, so the LFSR does not step then.
  assign lfsr_step = in_bounce && (tick == 32'd0) && !enter;

  keypad_matrix_emulator_bounce_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  (lfsr_step),
    .q     (lfsr_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    enter      = 1'b0;
    cnt_load   = 32'd0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          enter      = 1'b1;
          state_next = HAS_BOUNCE ? ST_B_IN : ST_HOLD;
          cnt_load   = HAS_BOUNCE ? BOUNCE_LOAD : HOLD_LOAD;
        end
      end
      ST_B_IN, ST_HOLD, ST_B_OUT: begin
        if (kp.abort) begin
          enter      = 1'b1;
          state_next = ST_GAP;
          cnt_load   = GAP_LOAD;
        end else if (phase_end) begin
          enter = 1'b1;
          case (state)
            ST_B_IN: begin
              state_next = ST_HOLD;
              cnt_load   = HOLD_LOAD;
            end
            ST_HOLD: begin
              state_next = HAS_BOUNCE ? ST_B_OUT : ST_GAP;
              cnt_load   = HAS_BOUNCE ? BOUNCE_LOAD : GAP_LOAD;
            end
            default: begin
              state_next = ST_GAP;
              cnt_load   = GAP_LOAD;
            end
          endcase
        end
      end
      ST_GAP: begin
        if (phase_end) begin
          enter      = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        enter      = 1'b1;
        state_next = ST_IDLE;
      end
    endcase
  end

  // Contact is solid in HOLD and released in GAP/IDLE; bounce phases start
  // from the previous contact level and then follow the LFSR.
  always_comb begin
    pressed_next = pressed;
    if (enter)          pressed_next = (state_next == ST_HOLD) || (state_next == ST_B_OUT);
    else if (lfsr_step) pressed_next = lfsr_q[0];
  end

  always_comb begin
    row_next = ROW_IDLE;
    if (pressed && !kp.col[key_col(key_q)]) row_next[key_row(key_q)] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= 32'd0;
      tick    <= 32'd0;
      pressed <= 1'b0;
      key_q   <= 4'd0;
      row_q   <= ROW_IDLE;
    end else begin
      if (enter)               cnt <= cnt_load;
      else if (cnt != 32'd0)   cnt <= cnt - 32'd1;
      if (enter || lfsr_step)  tick <= TICK_LOAD;
      else if (tick != 32'd0)  tick <= tick - 32'd1;
      if (accept)              key_q <= kp.req_key;
      pressed <= pressed_next;
      row_q   <= row_next;
    end
  end

  assign kp.req_ready = ready_int;
  assign kp.pressed   = pressed;
  assign kp.busy      = (state != ST_IDLE);
  assign kp.done      = (state == ST_GAP) && phase_end;
  assign kp.row       = row_q;
  assign kp.dbg_state = state;

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Bench for keypad_matrix_emulator: a no-bounce instance and a bouncing
// instance, each checked cycle by cycle against a timeline model.
module tb_keypad_matrix_emulator;
  import keypad_matrix_emulator_pkg::*;

  localparam int HOLD     = 200;
  localparam int GAP      = 50;
  localparam int TICK     = 4;
  localparam int B_HOLD   = 60;
  localparam int B_BOUNCE = 40;
  localparam int B_GAP    = 20;
  localparam logic [15:0] SEED = 16'hACE1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  keypad_matrix_emulator_if kif();
  keypad_matrix_emulator_if kif1();

  keypad_matrix_emulator #(
    .HOLD_CYCLES(HOLD), .BOUNCE_CYCLES(0), .BOUNCE_TICK(TICK),
    .GAP_CYCLES(GAP), .LFSR_SEED(SEED)
  ) dut (.clk(clk), .reset(reset), .kp(kif));

  keypad_matrix_emulator #(
    .HOLD_CYCLES(B_HOLD), .BOUNCE_CYCLES(B_BOUNCE), .BOUNCE_TICK(TICK),
    .GAP_CYCLES(B_GAP), .LFSR_SEED(SEED)
  ) dut_b (.clk(clk), .reset(reset), .kp(kif1));

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];   // expected done-pulse cycle numbers
  int done_seen = 0;
  int last_done_cyc = 0;
  logic       scan_hit;
  logic [3:0] scan_key;
  logic [15:0] mlfsr;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic logic [3:0] next_col(input int mode, input logic [3:0] sc, input int idx);
    logic [3:0] one;
    one = 4'b0001;
    if (mode == 1) return 4'($urandom_range(0, 15));
    if (mode == 2) return ~(one << ((idx / 4) % 4));
    return sc;
  endfunction

  function automatic logic [1:0] low_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (!v[i]) return 2'(i);
    return 2'd0;
  endfunction

  // ---------------- driver: one press on the no-bounce instance ----------------
  // Called #1 after a clock edge with the DUT idle. rel = edges since accept.
  task automatic run_press(input logic [3:0] key, input int col_mode,
                           input logic [3:0] static_col, input int abort_at,
                           input bit keep_valid);
    int end_hold, total;
    logic prev_pr, exp_pr, exp_busy, exp_done;
    logic [3:0] col_prev, exp_row;
    logic [31:0] exp_c;
    end_hold = (abort_at > 0 && abort_at <= HOLD) ? abort_at : HOLD;
    total    = end_hold + GAP;
    scan_hit = 1'b0;
    scan_key = 4'd0;
    kif.req_valid = 1'b1;
    kif.req_key   = key;
    kif.abort     = 1'b0;
    kif.col       = next_col(col_mode, static_col, 0);
    col_prev      = kif.col;
    prev_pr       = 1'b0;
    exp_q.push_back(32'(cyc + total));
    @(posedge clk); #1;
    kif.req_valid = keep_valid;
    kif.req_key   = 4'($urandom_range(0, 15));
    for (int rel = 0; rel <= total; rel++) begin
      if (rel > 0) begin @(posedge clk); #1; end
      exp_pr   = (rel < end_hold);
      exp_busy = (rel < total);
      exp_done = (rel == total - 1);
      exp_row  = 4'b1111;
      if (prev_pr && !col_prev[key[3:2]]) exp_row[key[1:0]] = 1'b0;
      checks += 5;
      if (kif.row !== exp_row) begin
        errors++; $display("FAIL row key=%0d rel=%0d got %b exp %b", key, rel, kif.row, exp_row);
      end
      if (kif.pressed !== exp_pr) begin
        errors++; $display("FAIL pressed key=%0d rel=%0d got %b exp %b", key, rel, kif.pressed, exp_pr);
      end
      if (kif.busy !== exp_busy) begin
        errors++; $display("FAIL busy key=%0d rel=%0d got %b exp %b", key, rel, kif.busy, exp_busy);
      end
      if (kif.done !== exp_done) begin
        errors++; $display("FAIL done key=%0d rel=%0d got %b exp %b", key, rel, kif.done, exp_done);
      end
      if (kif.req_ready !== !exp_busy) begin
        errors++; $display("FAIL req_ready key=%0d rel=%0d got %b exp %b", key, rel, kif.req_ready, !exp_busy);
      end
      if (kif.done === 1'b1) begin
        done_seen++;
        last_done_cyc = cyc;
        checks++;
        exp_c = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        if (32'(cyc) !== exp_c) begin
          errors++; $display("FAIL done_time got %0d exp %0d", cyc, exp_c);
        end
      end
      if (col_mode == 2 && kif.row !== 4'b1111) begin
        scan_hit = 1'b1;
        scan_key = {low_idx(col_prev), low_idx(kif.row)};
      end
      prev_pr   = exp_pr;
      kif.col   = next_col(col_mode, static_col, rel + 1);
      col_prev  = kif.col;
      kif.abort = (rel + 1 == abort_at) ||
                  (rel >= end_hold && col_mode == 1 && $urandom_range(0, 3) == 0);
      if (keep_valid) kif.req_key = 4'($urandom_range(0, 15));
    end
    kif.abort = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #3 reset = 1'b1;
    #1;
    checks += 6;
    if (kif.row !== 4'b1111)   begin errors++; $display("FAIL reset_row got %b exp 1111", kif.row); end
    if (kif.pressed !== 1'b0)  begin errors++; $display("FAIL reset_pressed got %b exp 0", kif.pressed); end
    if (kif.busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b exp 0", kif.busy); end
    if (kif.done !== 1'b0)     begin errors++; $display("FAIL reset_done got %b exp 0", kif.done); end
    if (kif.req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", kif.req_ready); end
    if (kif.dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d exp 0", kif.dbg_state); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (kif.req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b exp 1", kif.req_ready); end
  endtask

  task automatic test_reset_mid_hold();
    int any_done;
    kif.req_valid = 1'b1;
    kif.req_key   = 4'd6;
    kif.col       = 4'b1101;
    @(posedge clk); #1;
    kif.req_valid = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    checks++;
    if (kif.row !== 4'b1011) begin errors++; $display("FAIL mid_hold_row got %b exp 1011", kif.row); end
    #2 reset = 1'b1;
    #1;
    checks += 3;
    if (kif.row !== 4'b1111)  begin errors++; $display("FAIL async_reset_row got %b exp 1111", kif.row); end
    if (kif.busy !== 1'b0)    begin errors++; $display("FAIL async_reset_busy got %b exp 0", kif.busy); end
    if (kif.pressed !== 1'b0) begin errors++; $display("FAIL async_reset_pressed got %b exp 0", kif.pressed); end
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    checks += 3;
    if (kif.req_ready !== 1'b1) begin errors++; $display("FAIL rel_reset_ready got %b exp 1", kif.req_ready); end
    if (kif.busy !== 1'b0)      begin errors++; $display("FAIL rel_reset_busy got %b exp 0", kif.busy); end
    if (kif.row !== 4'b1111)    begin errors++; $display("FAIL rel_reset_row got %b exp 1111", kif.row); end
    any_done = 0;
    for (int i = 0; i < HOLD + GAP + 10; i++) begin
      @(posedge clk); #1;
      if (kif.done === 1'b1 || kif.row !== 4'b1111) any_done++;
    end
    checks++;
    if (any_done != 0) begin errors++; $display("FAIL lost_request got %0d events exp 0", any_done); end
  endtask

  task automatic test_static_col();
    run_press(4'd6, 0, 4'b1101, 0, 1'b0);
    run_press(4'd6, 0, 4'b1110, 0, 1'b0);
    run_press(4'd9, 0, 4'b0000, 0, 1'b0);
  endtask

  task automatic test_scan_keys();
    for (int k = 0; k < 16; k++) begin
      run_press(4'(k), 2, 4'b1111, 0, 1'b0);
      checks += 2;
      if (scan_hit !== 1'b1) begin errors++; $display("FAIL scan_flag key=%0d got %b exp 1", k, scan_hit); end
      if (scan_key !== 4'(k)) begin errors++; $display("FAIL scan_value got %0d exp %0d", scan_key, k); end
    end
  endtask

  task automatic test_back_to_back();
    int d0, first_done;
    d0 = done_seen;
    run_press(4'd3, 0, 4'b1110, 0, 1'b1);
    first_done = last_done_cyc;
    run_press(4'd3, 0, 4'b1110, 0, 1'b0);
    checks += 2;
    if (done_seen - d0 != 2) begin errors++; $display("FAIL b2b_done_count got %0d exp 2", done_seen - d0); end
    if (last_done_cyc - first_done < 250) begin
      errors++; $display("FAIL b2b_done_spacing got %0d exp >=250", last_done_cyc - first_done);
    end
  endtask

  task automatic test_abort();
    run_press(4'd11, 0, 4'b1011, 100, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_press(4'($urandom_range(0, 15)), 1, 4'b1111,
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, HOLD)) : 0, 1'b0);
    end
  endtask

  // One press on the bouncing instance; mlfsr carries the LFSR across presses.
  task automatic bounce_run(input logic [3:0] key);
    int total, loc;
    logic exp_p, prev_p;
    logic [3:0] exp_row;
    total = 2 * B_BOUNCE + B_HOLD + B_GAP;
    kif1.req_valid = 1'b1;
    kif1.req_key   = key;
    @(posedge clk); #1;
    kif1.req_valid = 1'b0;
    exp_p  = 1'b0;
    prev_p = 1'b0;
    for (int rel = 0; rel <= total; rel++) begin
      if (rel > 0) begin @(posedge clk); #1; end
      if (rel < B_BOUNCE) begin
        if (rel > 0 && rel % TICK == 0) begin exp_p = mlfsr[0]; mlfsr = lfsr_next(mlfsr); end
      end else if (rel < B_BOUNCE + B_HOLD) begin
        exp_p = 1'b1;
      end else if (rel < 2 * B_BOUNCE + B_HOLD) begin
        loc = rel - (B_BOUNCE + B_HOLD);
        if (loc > 0 && loc % TICK == 0) begin exp_p = mlfsr[0]; mlfsr = lfsr_next(mlfsr); end
      end else begin
        exp_p = 1'b0;
      end
      exp_row = 4'b1111;
      if (prev_p) exp_row[key[1:0]] = 1'b0;
      checks += 4;
      if (kif1.pressed !== exp_p) begin
        errors++; $display("FAIL bounce_pressed key=%0d rel=%0d got %b exp %b", key, rel, kif1.pressed, exp_p);
      end
      if (kif1.row !== exp_row) begin
        errors++; $display("FAIL bounce_row key=%0d rel=%0d got %b exp %b", key, rel, kif1.row, exp_row);
      end
      if (kif1.busy !== (rel < total)) begin
        errors++; $display("FAIL bounce_busy rel=%0d got %b exp %b", rel, kif1.busy, rel < total);
      end
      if (kif1.done !== (rel == total - 1)) begin
        errors++; $display("FAIL bounce_done rel=%0d got %b exp %b", rel, kif1.done, rel == total - 1);
      end
      prev_p = exp_p;
    end
  endtask

  task automatic test_bounce();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    mlfsr = SEED;
    bounce_run(4'd5);
    bounce_run(4'($urandom_range(0, 15)));
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    mlfsr = SEED;
    bounce_run(4'd5);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    kif.req_valid  = 1'b0; kif.req_key  = 4'd0; kif.abort  = 1'b0; kif.col  = 4'b1111;
    kif1.req_valid = 1'b0; kif1.req_key = 4'd0; kif1.abort = 1'b0; kif1.col = 4'b0000;
    test_reset();
    test_reset_mid_hold();
    test_static_col();
    test_scan_keys();
    test_back_to_back();
    test_abort();
    test_random();
    test_bounce();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
